// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: stage enables/clears, E-stage
// operand forwarding, multi-cycle mul/div sequencing, memory wait states and perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MULDIV_LAT     = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdW_i,
  input  logic                      LoadE_i,
  input  logic                      RegWriteM_i,
  input  logic                      RegWriteW_i,
  input  logic                      PCSrcE_i,
  input  logic                      MulDivStartE_i,
  input  logic                      MemReqM_i,
  input  logic                      MemReadyM_i,
  output logic                      StallF_o,
  output logic                      StallD_o,
  output logic                      StallE_o,
  output logic                      StallM_o,
  output logic                      FlushD_o,
  output logic                      FlushE_o,
  output logic                      FlushM_o,
  output logic                      FlushW_o,
  output logic [1:0]                ForwardAE_o,
  output logic [1:0]                ForwardBE_o,
  output logic                      MdDoneE_o,
  output logic [CNT_WIDTH-1:0]      StallCnt_o,
  output logic [CNT_WIDTH-1:0]      FlushCnt_o
);

  localparam int unsigned MdCntW = $clog2(MULDIV_LAT) + 1;
  localparam logic [MdCntW-1:0] MdCntLoad = (MULDIV_LAT > 1) ? MdCntW'(MULDIV_LAT - 2) : '0;
  localparam logic [MdCntW-1:0] MdCntOne  = MdCntW'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] RegZero = '0;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic {StRun, StMdBusy} state_e;

  state_e              state_q, state_d;
  logic [MdCntW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic lw_stall;
  logic branch_flush;
  logic [1:0] fwd_a, fwd_b;

  assign mem_stall = MemReqM_i & ~MemReadyM_i;
  assign lw_stall  = LoadE_i & (RdE_i != RegZero) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));

  // M result is younger than W result, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    if (RegWriteM_i && (RdM_i != RegZero) && (RdM_i == Rs1E_i)) begin
      fwd_a = 2'b10;
    end else if (RegWriteW_i && (RdW_i != RegZero) && (RdW_i == Rs1E_i)) begin
      fwd_a = 2'b01;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (RegWriteM_i && (RdM_i != RegZero) && (RdM_i == Rs2E_i)) begin
      fwd_b = 2'b10;
    end else if (RegWriteW_i && (RdW_i != RegZero) && (RdW_i == Rs2E_i)) begin
      fwd_b = 2'b01;
    end
  end

  // State register, mul/div countdown and perf counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic; a memory wait freezes the sequencer entirely.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (!mem_stall) begin
      unique case (state_q)
        StRun: begin
          if (MulDivStartE_i && (MULDIV_LAT > 1)) begin
            state_d  = StMdBusy;
            md_cnt_d = MdCntLoad;
          end
        end
        StMdBusy: begin
          if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MdCntOne;
          end else begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF_o && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (branch_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // Output logic. Priority: reset > memory wait > mul/div > load-use > branch.
  always_comb begin
    StallF_o     = 1'b0;
    StallD_o     = 1'b0;
    StallE_o     = 1'b0;
    StallM_o     = 1'b0;
    FlushD_o     = 1'b0;
    FlushE_o     = 1'b0;
    FlushM_o     = 1'b0;
    FlushW_o     = 1'b0;
    ForwardAE_o  = fwd_a;
    ForwardBE_o  = fwd_b;
    MdDoneE_o    = 1'b0;
    branch_flush = 1'b0;
    if (!rst_ni) begin
      FlushD_o    = 1'b1;
      FlushE_o    = 1'b1;
      FlushM_o    = 1'b1;
      FlushW_o    = 1'b1;
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;
    end else if (mem_stall) begin
      // E is frozen too, so a pending branch or load-use re-presents next cycle.
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      FlushW_o = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (MulDivStartE_i) begin
            if (MULDIV_LAT > 1) begin
              StallF_o = 1'b1;
              StallD_o = 1'b1;
              StallE_o = 1'b1;
              FlushM_o = 1'b1;
            end else begin
              MdDoneE_o = 1'b1;
            end
          end else begin
            StallF_o     = lw_stall;
            StallD_o     = lw_stall;
            FlushE_o     = lw_stall | PCSrcE_i;
            FlushD_o     = PCSrcE_i;
            branch_flush = PCSrcE_i;
          end
        end
        StMdBusy: begin
          if (md_cnt_q != '0) begin
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            FlushM_o = 1'b1;
          end else begin
            MdDoneE_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a LAT=4/32-bit-counter instance plus a LAT=1/4-bit
// instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic       loade, regwm, regww, pcsrce, mdstart, memreq, memrdy;

  logic        stf, std, ste, stm, fld, fle, flm, flw, mdd;
  logic [1:0]  fwa, fwb;
  logic [31:0] scnt, fcnt;

  logic        stf2, std2, ste2, stm2, fld2, fle2, flm2, flw2, mdd2;
  logic [1:0]  fwa2, fwb2;
  logic [3:0]  scnt2, fcnt2;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned exp_sc = 0;
  int unsigned exp_fc = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LAT(4), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .LoadE_i(loade), .RegWriteM_i(regwm), .RegWriteW_i(regww), .PCSrcE_i(pcsrce),
    .MulDivStartE_i(mdstart), .MemReqM_i(memreq), .MemReadyM_i(memrdy),
    .StallF_o(stf), .StallD_o(std), .StallE_o(ste), .StallM_o(stm),
    .FlushD_o(fld), .FlushE_o(fle), .FlushM_o(flm), .FlushW_o(flw),
    .ForwardAE_o(fwa), .ForwardBE_o(fwb), .MdDoneE_o(mdd),
    .StallCnt_o(scnt), .FlushCnt_o(fcnt)
  );

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MULDIV_LAT(1), .CNT_WIDTH(4)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .LoadE_i(loade), .RegWriteM_i(regwm), .RegWriteW_i(regww), .PCSrcE_i(pcsrce),
    .MulDivStartE_i(mdstart), .MemReqM_i(memreq), .MemReadyM_i(memrdy),
    .StallF_o(stf2), .StallD_o(std2), .StallE_o(ste2), .StallM_o(stm2),
    .FlushD_o(fld2), .FlushE_o(fle2), .FlushM_o(flm2), .FlushW_o(flw2),
    .ForwardAE_o(fwa2), .ForwardBE_o(fwb2), .MdDoneE_o(mdd2),
    .StallCnt_o(scnt2), .FlushCnt_o(fcnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,MdDone} for compact checks.
  function automatic logic [31:0] ctl1();
    return {23'd0, stf, std, ste, stm, fld, fle, flm, flw, mdd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
    loade = 0; regwm = 0; regww = 0; pcsrce = 0; mdstart = 0; memreq = 0; memrdy = 0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    rdm = 5; rdw = 5; rs1e = 5; regwm = 1; regww = 1;
    #2;
    // Reset: all flushes, no stalls, forwarding forced to regfile.
    check("reset_ctl", ctl1(), 32'b0000_1111_0);
    check("reset_fwa", {30'd0, fwa}, 32'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    #1;
    check("idle_ctl", ctl1(), 32'd0);
    check("idle_scnt", scnt, 32'd0);

    // Reset in the middle of a mul/div op.
    mdstart = 1;
    tick();
    check("md_busy_pre_rst", ctl1(), 32'b1110_0010_0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", ctl1(), 32'b0000_1111_0);
    check("mid_rst_scnt", scnt, 32'd0);
    tick();
    rst_n = 1'b1;
    mdstart = 0;
    #1;
    check("post_rst_run", ctl1(), 32'd0);
    check("post_rst_scnt", scnt, 32'd0);
    check("post_rst_fcnt", fcnt, 32'd0);

    // Forwarding.
    rdm = 5; rdw = 5; rs1e = 5; regwm = 1; regww = 1; rs2e = 0;
    #1;
    check("fwd_a_m", {30'd0, fwa}, 32'd2);
    check("fwd_b_zero", {30'd0, fwb}, 32'd0);
    rdm = 0;
    #1;
    check("fwd_a_w", {30'd0, fwa}, 32'd1);
    rdm = 5; regwm = 0; rs2e = 5;
    #1;
    check("fwd_a_m_nowrite", {30'd0, fwa}, 32'd1);
    check("fwd_b_w", {30'd0, fwb}, 32'd1);
    regww = 0;
    #1;
    check("fwd_b_none", {30'd0, fwb}, 32'd0);
    clear_inputs();

    // Load-use.
    loade = 1; rde = 7; rs2d = 7;
    #1;
    check("lw_ctl", ctl1(), 32'b1100_0100_0);
    tick();
    exp_sc++;
    loade = 0;
    #1;
    check("lw_done_ctl", ctl1(), 32'd0);
    check("lw_scnt", scnt, exp_sc);
    loade = 1; rde = 0; rs2d = 0;
    #1;
    check("lw_rd0_ctl", ctl1(), 32'd0);
    tick();
    check("lw_rd0_scnt", scnt, exp_sc);
    clear_inputs();

    // Branch, then branch with load-use.
    pcsrce = 1;
    #1;
    check("br_ctl", ctl1(), 32'b0000_1100_0);
    tick();
    exp_fc++;
    pcsrce = 0;
    #1;
    check("br_fcnt", fcnt, exp_fc);
    pcsrce = 1; loade = 1; rde = 7; rs1d = 7;
    #1;
    check("br_lw_ctl", ctl1(), 32'b1100_1100_0);
    tick();
    exp_sc++; exp_fc++;
    clear_inputs();
    #1;
    check("br_lw_scnt", scnt, exp_sc);
    check("br_lw_fcnt", fcnt, exp_fc);

    // Mul/div, LAT=4 with a memory wait at md_cnt=1; LAT=1 instance completes at once.
    mdstart = 1;
    #1;
    check("md_c0", ctl1(), 32'b1110_0010_0);
    check("md_lat1_done", {30'd0, stf2, mdd2}, 32'b01);
    tick();
    check("md_c1", ctl1(), 32'b1110_0010_0);
    tick();
    memreq = 1; memrdy = 0;
    #1;
    check("md_mem0", ctl1(), 32'b1111_0001_0);
    tick();
    check("md_mem1", ctl1(), 32'b1111_0001_0);
    tick();
    memrdy = 1;
    #1;
    check("md_c2", ctl1(), 32'b1110_0010_0);
    tick();
    memreq = 0; memrdy = 0;
    #1;
    check("md_done", ctl1(), 32'b0000_0000_1);
    tick();
    exp_sc += 5;
    mdstart = 0;
    #1;
    check("md_back_run", ctl1(), 32'd0);
    check("md_scnt", scnt, exp_sc);

    // Memory wait masks a branch in RUN; branch is not counted.
    memreq = 1; pcsrce = 1;
    #1;
    check("mem_br_ctl", ctl1(), 32'b1111_0001_0);
    tick();
    exp_sc++;
    clear_inputs();
    #1;
    check("mem_br_fcnt", fcnt, exp_fc);
    check("mem_br_scnt", scnt, exp_sc);

    // Saturation of the 4-bit instance.
    loade = 1; rde = 3; rs1d = 3;
    for (int i = 0; i < 20; i++) tick();
    exp_sc += 20;
    clear_inputs();
    #1;
    check("sat_scnt2", {28'd0, scnt2}, 32'd15);
    check("sat_scnt", scnt, exp_sc);
    tick();
    check("sat_hold_scnt2", {28'd0, scnt2}, 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
